// File: rtl/bram_burst_reader.sv
// Read-side BRAM master: turns a (start, length) command into sequential reads and streams the
// words out on valid/ready. Define BRAM_RD_WRAP_EN to wrap addresses modulo RAM_DEPTH.
module bram_burst_reader #(
    parameter int unsigned RAM_WIDTH    = 32,
    parameter int unsigned RAM_DEPTH    = 512,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH   = READ_LATENCY + 2,
    localparam int unsigned AW          = $clog2(RAM_DEPTH)
) (
    input  logic                 clka,
    input  logic                 rstb,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [AW-1:0]        cmd_addr,
    input  logic [AW:0]          cmd_len,
    output logic                 cmd_err,
    output logic                 bram_en,
    output logic                 bram_we,
    output logic [AW-1:0]        bram_addr,
    output logic [RAM_WIDTH-1:0] bram_din,
    output logic                 bram_regce,
    output logic                 bram_rst,
    input  logic [RAM_WIDTH-1:0] bram_dout,
    output logic [RAM_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW+1:0] DepthExt = (AW + 2)'(RAM_DEPTH);

    if (READ_LATENCY < 1 || FIFO_DEPTH < READ_LATENCY + 1) begin : g_bad_cfg
        $error("bram_burst_reader: FIFO_DEPTH must be >= READ_LATENCY+1 and READ_LATENCY >= 1");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d, addr_inc;
    logic [AW:0]           remain_q, remain_d;
    logic [AW:0]           len_q, len_d;
    logic [AW:0]           beat_q, beat_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;
    logic                  rst_hold_q;
    logic [READ_LATENCY-1:0] pipe_q, pipe_d;

    logic [RAM_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    logic                  cmd_rdy, cmd_legal, issue, push, pop, last_beat, fifo_nonempty;
    logic [CW:0]           occupancy;
    logic [AW+1:0]         range_end;

    function automatic logic [CW:0] ones(input logic [READ_LATENCY-1:0] v);
        ones = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            ones = ones + (CW + 1)'(v[i]);
        end
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Command legality: length 1..RAM_DEPTH, and without wrap the burst must stay in range.
    assign range_end = {2'b00, cmd_addr} + {1'b0, cmd_len};

    always_comb begin
        cmd_legal = (cmd_len != '0) && ({1'b0, cmd_len} <= DepthExt) &&
                    ({2'b00, cmd_addr} < DepthExt);
`ifndef BRAM_RD_WRAP_EN
        if (range_end > DepthExt) begin
            cmd_legal = 1'b0;
        end
`endif
    end

    always_comb begin
`ifdef BRAM_RD_WRAP_EN
        addr_inc = (addr_q == AW'(RAM_DEPTH - 1)) ? '0 : addr_q + 1'b1;
`else
        addr_inc = addr_q + 1'b1;
`endif
    end

    // The cycle straight after reset still refuses commands.
    assign cmd_rdy       = (state_q == StIdle) && !rst_hold_q;
    assign fifo_nonempty = (count_q != '0);
    assign occupancy     = ones(pipe_q) + {1'b0, count_q};
    assign issue         = (state_q == StRun) && (remain_q != '0) &&
                           (occupancy < (CW + 1)'(FIFO_DEPTH));
    assign push          = pipe_q[READ_LATENCY-1];
    assign pop           = fifo_nonempty && m_ready;
    assign last_beat     = ((beat_q + 1'b1) == len_q);

    if (READ_LATENCY == 1) begin : g_pipe1
        assign pipe_d = issue;
    end else begin : g_pipen
        assign pipe_d = {pipe_q[READ_LATENCY-2:0], issue};
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        len_d    = len_q;
        beat_d   = beat_q;
        err_d    = 1'b0;
        done_d   = 1'b0;
        if (pop) begin
            beat_d = beat_q + 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_rdy) begin
                    if (cmd_legal) begin
                        state_d  = StRun;
                        addr_d   = cmd_addr;
                        remain_d = cmd_len;
                        len_d    = cmd_len;
                        beat_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (issue) begin
                    addr_d   = addr_inc;
                    remain_d = remain_q - 1'b1;
                    if (remain_q == (AW + 1)'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && last_beat) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rstb) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            remain_q   <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            rst_hold_q <= 1'b1;
            pipe_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
            done_q     <= done_d;
            rst_hold_q <= 1'b0;
            pipe_q     <= pipe_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clka) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bram_dout;
        end
    end

    // Outputs are forced to their idle values while reset is held.
    assign cmd_ready  = cmd_rdy && !rstb;
    assign cmd_err    = err_q && !rstb;
    assign bram_en    = issue && !rstb;
    assign bram_we    = 1'b0;
    assign bram_addr  = rstb ? '0 : addr_q;
    assign bram_din   = '0;
    assign bram_regce = 1'b1;
    assign bram_rst   = rstb;
    assign m_valid    = fifo_nonempty && !rstb;
    assign m_data     = fifo_mem[rd_ptr_q];
    assign m_last     = fifo_nonempty && last_beat && !rstb;
    assign busy       = (state_q != StIdle) && !rstb;
    assign done       = done_q && !rstb;

endmodule

// File: tb/tb_bram_burst_reader.sv
// Bench for bram_burst_reader: READ_LATENCY=1 and 2 instances share stimulus; a burst-level
// model checks every cycle and literal expectations pin the model.
module tb_bram_burst_reader;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW    = 9;

    logic          clka      = 1'b0;
    logic          rstb      = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [AW:0]   cmd_len   = '0;
    logic          m_ready   = 1'b1;
    int            ready_mode = 0;

    logic [1:0]    cmd_ready_w, cmd_err_w, bram_en_w, bram_we_w, bram_regce_w, bram_rst_w;
    logic [1:0]    m_valid_w, m_last_w, busy_w, done_w;
    logic [AW-1:0] bram_addr_w [2];
    logic [W-1:0]  bram_din_w [2];
    logic [W-1:0]  bram_dout_w [2];
    logic [W-1:0]  m_data_w [2];
    logic [W-1:0]  mem [DEPTH];

    always #5 clka = ~clka;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [W-1:0] q1, q2;
        always @(posedge clka) begin
            if (bram_en_w[g]) q1 <= mem[bram_addr_w[g]];
            q2 <= q1;
        end
        assign bram_dout_w[g] = (g == 0) ? q1 : q2;

        bram_burst_reader #(
            .RAM_WIDTH   (W),
            .RAM_DEPTH   (DEPTH),
            .READ_LATENCY(g + 1)
        ) u_dut (
            .clka      (clka),
            .rstb      (rstb),
            .cmd_valid (cmd_valid),
            .cmd_ready (cmd_ready_w[g]),
            .cmd_addr  (cmd_addr),
            .cmd_len   (cmd_len),
            .cmd_err   (cmd_err_w[g]),
            .bram_en   (bram_en_w[g]),
            .bram_we   (bram_we_w[g]),
            .bram_addr (bram_addr_w[g]),
            .bram_din  (bram_din_w[g]),
            .bram_regce(bram_regce_w[g]),
            .bram_rst  (bram_rst_w[g]),
            .bram_dout (bram_dout_w[g]),
            .m_data    (m_data_w[g]),
            .m_valid   (m_valid_w[g]),
            .m_ready   (m_ready),
            .m_last    (m_last_w[g]),
            .busy      (busy_w[g]),
            .done      (done_w[g])
        );
    end

    // Counters and model state: written only by the compare process.
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit rst_prev = 1'b1;
    int act [2], pops [2], issues [2], start [2], blen [2], since [2];
    int first_seen [2], first_cyc [2], last_cyc [2], lastw [2];
    int dut_err [2], dut_done [2], dut_beats [2];
    int got [2][8];
    bit err_pend [2], done_pend [2], prev_stall [2];

    // Literal-expectation mailbox from the stimulus process.
    string  lit_name;
    longint lit_act, lit_exp;
    int     lit_seq  = 0;
    int     lit_done = 0;

    function automatic bit legal(input int a, input int l);
`ifdef BRAM_RD_WRAP_EN
        legal = (l != 0) && (l <= DEPTH) && (a < DEPTH);
`else
        legal = (l != 0) && (l <= DEPTH) && (a + l <= DEPTH);
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    always @(negedge clka) begin
        cyc++;
        if (lit_seq != lit_done) begin
            chk(lit_name, lit_act, lit_exp);
            lit_done = lit_seq;
        end
        for (int g = 0; g < 2; g++) begin
            int lat;
            bit exp_en, nerr, ndone;
            lat = g + 1;
            chk($sformatf("tieoff[%0d]", g),
                {bram_we_w[g], bram_regce_w[g], bram_rst_w[g], bram_din_w[g]},
                {1'b0, 1'b1, rstb, 32'h0});
            dut_err[g]  += int'(cmd_err_w[g]);
            dut_done[g] += int'(done_w[g]);
            if (rstb || rst_prev) begin
                chk($sformatf("reset_outs[%0d]", g),
                    {bram_en_w[g], m_valid_w[g], m_last_w[g], busy_w[g], done_w[g],
                     cmd_err_w[g], cmd_ready_w[g], bram_addr_w[g]}, 64'h0);
                act[g] = 0;
                err_pend[g] = 1'b0;
                done_pend[g] = 1'b0;
                prev_stall[g] = 1'b0;
            end else begin
                since[g]++;
                chk($sformatf("ctl[%0d]", g),
                    {cmd_err_w[g], done_w[g], busy_w[g], cmd_ready_w[g]},
                    {err_pend[g], done_pend[g], act[g] != 0, act[g] == 0});
                exp_en = (act[g] != 0) && (issues[g] < blen[g]) && (issues[g] - pops[g] < lat + 2);
                chk($sformatf("bram_en[%0d]", g), bram_en_w[g], exp_en);
                if (exp_en) begin
                    chk($sformatf("bram_addr[%0d]", g), bram_addr_w[g],
                        AW'((start[g] + issues[g]) % DEPTH));
                    issues[g]++;
                end
                if (prev_stall[g]) chk($sformatf("stall_hold[%0d]", g), m_valid_w[g], 1);
                nerr = 1'b0;
                ndone = 1'b0;
                if (m_valid_w[g]) begin
                    if (first_seen[g] == 0) begin
                        chk($sformatf("first_lat[%0d]", g), since[g], lat + 2);
                        first_seen[g] = 1;
                        first_cyc[g] = cyc;
                    end
                    chk($sformatf("beat[%0d]", g), {act[g] != 0, m_last_w[g], m_data_w[g]},
                        {1'b1, pops[g] + 1 == blen[g], W'((start[g] + pops[g]) % DEPTH)});
                    if (m_ready) begin
                        if (pops[g] < 8) got[g][pops[g]] = int'(m_data_w[g]);
                        if (m_last_w[g]) lastw[g] = int'(m_data_w[g]);
                        last_cyc[g] = cyc;
                        dut_beats[g]++;
                        pops[g]++;
                        if (pops[g] == blen[g]) begin
                            act[g] = 0;
                            ndone = 1'b1;
                        end
                    end
                end
                prev_stall[g] = m_valid_w[g] && !m_ready;
                if (cmd_valid && cmd_ready_w[g]) begin
                    if (legal(int'(cmd_addr), int'(cmd_len))) begin
                        act[g] = 1;
                        start[g] = int'(cmd_addr);
                        blen[g] = int'(cmd_len);
                        pops[g] = 0;
                        issues[g] = 0;
                        since[g] = 0;
                        first_seen[g] = 0;
                        dut_beats[g] = 0;
                    end else begin
                        nerr = 1'b1;
                    end
                end
                err_pend[g] = nerr;
                done_pend[g] = ndone;
            end
        end
        rst_prev = rstb;
    end

    // Stimulus tasks start and end just after a rising edge.
    task automatic lit(input string name, input longint actual, input longint expected);
        lit_name = name;
        lit_act = actual;
        lit_exp = expected;
        lit_seq++;
        @(negedge clka);
        @(posedge clka);
        #1;
    endtask

    task automatic send(input int a, input int l);
        int t;
        t = 0;
        while (cmd_ready_w != 2'b11 && t < 1000) begin
            @(posedge clka);
            #1;
            t++;
        end
        if (t >= 1000) lit("send_ready_timeout", t, 0);
        cmd_addr = AW'(a);
        cmd_len = (AW + 1)'(l);
        cmd_valid = 1'b1;
        @(posedge clka);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        repeat (2) @(posedge clka);
        #1;
        while ((busy_w != 2'b00 || cmd_ready_w != 2'b11) && t < budget) begin
            @(posedge clka);
            #1;
            t++;
        end
        lit("idle_reached", {busy_w, cmd_ready_w}, 4'b0011);
    endtask

    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clka);
            #1;
            if (ready_mode == 1) begin
                m_ready = (ph % 3 == 0);
                ph++;
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, d0;
        for (int i = 0; i < DEPTH; i++) mem[i] = W'(i);
        repeat (3) @(posedge clka);
        #1;
        rstb = 1'b0;

        send(5, 4);
        wait_idle(200);
        lit("a_w0", got[1][0], 5);
        lit("a_w1", got[1][1], 6);
        lit("a_w2", got[1][2], 7);
        lit("a_w3", got[1][3], 8);
        lit("a_last", lastw[1], 8);
        lit("a_l1_w3", got[0][3], 8);
        lit("a_done", dut_done[1], 1);

        ready_mode = 1;
        send(5, 4);
        wait_idle(300);
        ready_mode = 0;
        lit("b_w0", got[1][0], 5);
        lit("b_w3", got[1][3], 8);
        lit("b_beats", dut_beats[1], 4);
        lit("b_done", dut_done[1], 2);

        e0 = dut_err[1];
        send(510, 4);
        wait_idle(200);
`ifdef BRAM_RD_WRAP_EN
        lit("wrap_w0", got[1][0], 510);
        lit("wrap_w1", got[1][1], 511);
        lit("wrap_w2", got[1][2], 0);
        lit("wrap_w3", got[1][3], 1);
        lit("wrap_err", dut_err[1], e0);
`else
        lit("range_err", dut_err[1], e0 + 1);
        lit("range_err_l1", dut_err[0], e0 + 1);
`endif

        e0 = dut_err[1];
        send(7, 0);
        wait_idle(200);
        lit("len0_err", dut_err[1], e0 + 1);

        send(0, 512);
        wait_idle(3000);
        for (int g = 0; g < 2; g++) begin
            lit($sformatf("full_beats[%0d]", g), dut_beats[g], 512);
            lit($sformatf("full_span[%0d]", g), last_cyc[g] - first_cyc[g], 511);
            lit($sformatf("full_last[%0d]", g), lastw[g], 511);
        end

        d0 = dut_done[1];
        send(0, 64);
        repeat (6) @(posedge clka);
        #1;
        rstb = 1'b1;
        @(posedge clka);
        #1;
        rstb = 1'b0;
        send(0, 2);
        wait_idle(200);
        lit("rst_w0", got[1][0], 0);
        lit("rst_w1", got[1][1], 1);
        lit("rst_done", dut_done[1], d0 + 1);

        repeat (3) @(posedge clka);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
